instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/simpleproc_pkg.sv | 18 +
 rtl/fetch_branch_detect.sv | 13 +
 rtl/instruction_fetch.sv | 100 ++++++++++
 tb/tb_instruction_fetch.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simpleproc_pkg.sv
// rtl/simpleproc_pkg.sv - shared fetch FSM state type, opcode constants and default widths
package simpleproc_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_IW = 16;

  localparam logic [3:0] OPC_BR = 4'hF;
  localparam logic [3:0] OPC_BZ = 4'hE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_BRANCH
  } fetch_state_t;

endpackage

// File: rtl/fetch_branch_detect.sv
// rtl/fetch_branch_detect.sv - decides whether a fetched opcode redirects the PC
module fetch_branch_detect #(
  parameter logic [3:0] OP_BR = 4'hF,
  parameter logic [3:0] OP_BZ = 4'hE
) (
  input  logic [3:0] opcode,
  input  logic       zero_flag,
  output logic       is_branch
);

  assign is_branch = (opcode == OP_BR) || ((opcode == OP_BZ) && zero_flag);

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch FSM: memory request, decoder handoff, branch redirect
module instruction_fetch
  import simpleproc_pkg::*;
#(
  parameter int         AW    = DEF_AW,
  parameter int         IW    = DEF_IW,
  parameter logic [3:0] OP_BR = OPC_BR,
  parameter logic [3:0] OP_BZ = OPC_BZ
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc,
  input  logic          zero_flag,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [IW-1:0] mem_rdata,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic          pc_en,
  output logic          take_branch,
  output logic [7:0]    immediate,
  output logic [7:0]    fetch_count,
  output logic          fetch_err
);

  fetch_state_t state_q, state_d;
  logic [IW-1:0] instr_q;
  logic          is_branch;
  logic          granted;
  logic          accepted;
  logic          proto_err;

  fetch_branch_detect #(
    .OP_BR (OP_BR),
    .OP_BZ (OP_BZ)
  ) u_branch_detect (
    .opcode    (mem_rdata[IW-1:IW-4]),
    .zero_flag (zero_flag),
    .is_branch (is_branch)
  );

  assign granted   = (state_q == ST_REQ) && mem_req && mem_gnt;
  assign accepted  = (state_q == ST_HOLD) && instr_ready;
  assign proto_err = (mem_rvalid && (state_q != ST_WAIT)) ||
                     (mem_gnt && !((state_q == ST_REQ) && mem_req));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_REQ;
      ST_REQ:    if (granted) state_d = ST_WAIT;
      ST_WAIT:   if (mem_rvalid) state_d = is_branch ? ST_BRANCH : ST_HOLD;
      ST_HOLD:   if (instr_ready) state_d = ST_REQ;
      ST_BRANCH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // The REQ cycle that carries the pc_en pulse keeps mem_req low, so the
  // request goes out only once the incremented pc is visible on the input.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_req     <= 1'b0;
      instr_q     <= '0;
      pc_en       <= 1'b0;
      fetch_count <= 8'h00;
      fetch_err   <= 1'b0;
    end else begin
      mem_req <= (state_q == ST_IDLE) || ((state_q == ST_REQ) && !granted);
      pc_en   <= accepted;
      if ((state_q == ST_WAIT) && mem_rvalid) begin
        instr_q <= mem_rdata;
      end
      if (accepted) begin
        fetch_count <= fetch_count + 8'd1;
      end
      if (proto_err) begin
        fetch_err <= 1'b1;
      end
    end
  end

  assign mem_addr    = mem_req ? pc : '0;
  assign instr       = instr_q;
  assign instr_valid = (state_q == ST_HOLD);
  assign take_branch = (state_q == ST_BRANCH);
  assign immediate   = take_branch ? instr_q[7:0] : 8'h00;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch with memory and PC models
module tb_instruction_fetch;

  typedef struct {
    logic [15:0] data;
    logic [7:0]  addr;
    int          gwait;
  } rom_t;

  typedef struct {
    bit          br;
    logic [15:0] data;
    logic [7:0]  imm;
    logic [7:0]  cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  pc = 8'h00;
  logic        zero_flag = 1'b0;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic        pc_en;
  logic        take_branch;
  logic [7:0]  immediate;
  logic [7:0]  fetch_count;
  logic        fetch_err;

  int          total = 0;
  int          bad = 0;
  rom_t        rom_q[$];
  exp_t        sb_q[$];
  logic [7:0]  exp_cnt = 8'h00;
  bit          mem_auto = 1'b1;
  bit          burst = 1'b0;
  bit          acc_pend = 1'b0;
  bit          rv_pending = 1'b0;
  logic [15:0] rv_data = 16'h0000;

  instruction_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .zero_flag   (zero_flag),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .pc_en       (pc_en),
    .take_branch (take_branch),
    .immediate   (immediate),
    .fetch_count (fetch_count),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=timeout required=done", name);
  endtask

  // PC register of the surrounding core
  initial begin
    logic       inc, br;
    logic [7:0] imm;
    forever begin
      @(negedge clk);
      inc = pc_en;
      br  = take_branch;
      imm = immediate;
      @(posedge clk);
      #1;
      if (inc) pc = pc + 8'd1;
      if (br)  pc = pc + imm;
    end
  end

  // Instruction memory: grant after gwait cycles, data one cycle after grant
  initial begin
    int   delay = 0;
    rom_t r;
    forever begin
      @(negedge clk);
      if (mem_auto) begin
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        if (rv_pending) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rv_data;
          rv_pending = 1'b0;
        end
        if (mem_req && rom_q.size() > 0) begin
          if (delay < rom_q[0].gwait) begin
            delay++;
          end else begin
            r = rom_q.pop_front();
            delay = 0;
            mem_gnt = 1'b1;
            rv_pending = 1'b1;
            rv_data = r.data;
            check("mem_addr_at_grant", {24'h0, mem_addr}, {24'h0, r.addr});
          end
        end
      end
    end
  end

  // Monitor
  initial begin
    int   cyc = 0;
    int   last_pe = -1;
    logic [7:0] acc_cnt = 8'h00;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!burst) last_pe = -1;
      if (acc_pend) begin
        acc_pend = 1'b0;
        check("pc_en_pulse", {31'h0, pc_en}, 32'h1);
        check("fetch_count", {24'h0, fetch_count}, {24'h0, acc_cnt});
        if (burst && last_pe >= 0) check("throughput", cyc - last_pe, 32'd4);
        last_pe = cyc;
      end else if (pc_en) begin
        check("spurious_pc_en", {31'h0, pc_en}, 32'h0);
      end
      if (instr_valid && instr_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_instr", {16'h0, instr}, 32'h0);
        end else begin
          e = sb_q.pop_front();
          check("kind_instr", {31'h0, e.br}, 32'h0);
          check("instr", {16'h0, instr}, {16'h0, e.data});
          acc_pend = 1'b1;
          acc_cnt  = e.cnt;
        end
      end
      if (take_branch) begin
        check("pc_en_with_branch", {31'h0, pc_en}, 32'h0);
        check("valid_in_branch", {31'h0, instr_valid}, 32'h0);
        if (sb_q.size() == 0) begin
          check("unexpected_branch", {24'h0, immediate}, 32'h0);
        end else begin
          e = sb_q.pop_front();
          check("kind_branch", {31'h0, e.br}, 32'h1);
          check("immediate", {24'h0, immediate}, {24'h0, e.imm});
          check("count_on_branch", {24'h0, fetch_count}, {24'h0, e.cnt});
        end
      end
    end
  end

  task automatic push_vec(input logic [15:0] d, input logic [7:0] a, input bit br,
                          input logic [7:0] imm, input int gw);
    rom_t r;
    exp_t e;
    r.data = d; r.addr = a; r.gwait = gw;
    rom_q.push_back(r);
    if (!br) exp_cnt = exp_cnt + 8'd1;
    e.br = br; e.data = d; e.imm = imm; e.cnt = exp_cnt;
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((sb_q.size() != 0 || rom_q.size() != 0 || acc_pend) && n < budget);
    if (sb_q.size() != 0 || rom_q.size() != 0 || acc_pend) fail_now(name);
  endtask

  task automatic run_vec(input logic [15:0] d, input logic [7:0] a, input bit zf,
                         input bit br, input logic [7:0] imm, input int gw);
    zero_flag = zf;
    push_vec(d, a, br, imm, gw);
    wait_done("vector_done", 60);
  endtask

  task automatic check_reset_outputs();
    check("rst_mem_req", {31'h0, mem_req}, 32'h0);
    check("rst_mem_addr", {24'h0, mem_addr}, 32'h0);
    check("rst_instr", {16'h0, instr}, 32'h0);
    check("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_pc_en", {31'h0, pc_en}, 32'h0);
    check("rst_take_branch", {31'h0, take_branch}, 32'h0);
    check("rst_immediate", {24'h0, immediate}, 32'h0);
    check("rst_fetch_count", {24'h0, fetch_count}, 32'h0);
    check("rst_fetch_err", {31'h0, fetch_err}, 32'h0);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b1;

    run_vec(16'h1234, 8'h00, 1'b0, 1'b0, 8'h00, 0);
    run_vec(16'hF005, 8'h01, 1'b0, 1'b1, 8'h05, 0);
    run_vec(16'hE0FE, 8'h06, 1'b1, 1'b1, 8'hFE, 0);
    run_vec(16'hE0FE, 8'h04, 1'b0, 1'b0, 8'h00, 0);

    // Decoder stall in HOLD
    instr_ready = 1'b0;
    push_vec(16'hABCD, 8'h05, 1'b0, 8'h00, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_valid && n < 30);
    if (!instr_valid) fail_now("stall_reach_hold");
    repeat (5) begin
      @(negedge clk);
      check("stall_instr", {16'h0, instr}, 32'h0000ABCD);
      check("stall_valid", {31'h0, instr_valid}, 32'h1);
      check("stall_pc_en", {31'h0, pc_en}, 32'h0);
      check("stall_mem_req", {31'h0, mem_req}, 32'h0);
    end
    @(posedge clk);
    #1 instr_ready = 1'b1;
    wait_done("stall_release", 60);

    run_vec(16'h0042, 8'h06, 1'b0, 1'b0, 8'h00, 2);

    // Reset while waiting for read data, then a late rvalid
    mem_auto = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < 30);
    if (!mem_req) fail_now("manual_req");
    check("manual_addr", {24'h0, mem_addr}, 32'h7);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 16'h5555;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("late_rvalid_err", {31'h0, fetch_err}, 32'h1);
    check("late_rvalid_instr", {16'h0, instr}, 32'h0);
    check("late_rvalid_valid", {31'h0, instr_valid}, 32'h0);
    check("late_rvalid_count", {24'h0, fetch_count}, 32'h0);
    check("restart_req", {31'h0, mem_req}, 32'h1);
    check("restart_addr", {24'h0, mem_addr}, 32'h7);
    exp_cnt = 8'h00;
    rv_pending = 1'b0;
    mem_auto = 1'b1;
    run_vec(16'h1111, 8'h07, 1'b0, 1'b0, 8'h00, 0);
    check("err_sticky", {31'h0, fetch_err}, 32'h1);

    // Clean reset, then 256 back-to-back fetches
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_cnt = 8'h00;
    check("err_cleared", {31'h0, fetch_err}, 32'h0);
    zero_flag = 1'b0;
    burst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      push_vec(16'h0100 + 16'(i), 8'(8 + i), 1'b0, 8'h00, 0);
    end
    wait_done("burst_done", 2000);
    burst = 1'b0;
    check("wrap_count", {24'h0, fetch_count}, 32'h0);
    check("wrap_err", {31'h0, fetch_err}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
